// File: rtl/tick_scheduler.sv
// tick_scheduler: three programmable tick channels, each producing a
// one-cycle enable pulse and a toggling level. Channels are sequenced by a
// run/pause state machine, and their periods can be reconfigured at run time
// through a valid/ready port. A request made while running waits in a single
// pending slot so that a channel's period never changes in mid-interval.
module tick_scheduler #(
  parameter int          CW         = 28,
  parameter int unsigned P0_DEFAULT = 50000000,
  parameter int unsigned P1_DEFAULT = 80000000,
  parameter int unsigned P2_DEFAULT = 110000000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          pause,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [1:0]    cfg_ch,
  input  logic [CW-1:0] cfg_period,
  output logic [2:0]    tick,
  output logic [2:0]    lvl,
  output logic [1:0]    state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

  state_t        state_q;
  logic [CW-1:0] period [3];
  logic [CW-1:0] cnt    [3];
  logic          pend_valid;
  logic [1:0]    pend_ch;
  logic [CW-1:0] pend_period;

  logic          count_en;
  logic          accept;
  logic          latch;
  logic          pend_drop;
  logic          pend_done;
  logic [2:0]    wrap;
  logic [2:0]    pend_hit;
  logic [2:0]    wr_direct;

  assign state     = state_q;
  assign cfg_ready = ~pend_valid;

  // Decide which channels wrap on this edge and where any configuration lands.
  // A pending value lands on its channel's wrap, or at once if that channel is
  // disabled, if counting is not happening on this edge, or if it targets
  // channel 3 (in which case it is simply discarded).
  always_comb begin
    count_en  = (state_q == RUN) && run;
    accept    = cfg_valid && !pend_valid;
    latch     = accept && (state_q == RUN);
    pend_drop = pend_valid && (pend_ch == 2'd3);
    wrap      = '0;
    pend_hit  = '0;
    wr_direct = '0;
    for (int i = 0; i < 3; i++) begin
      wrap[i]      = count_en && (period[i] != '0) && (cnt[i] == period[i]);
      pend_hit[i]  = pend_valid && (pend_ch == 2'(i)) &&
                     (wrap[i] || !count_en || (period[i] == '0));
      wr_direct[i] = accept && (state_q != RUN) && (cfg_ch == 2'(i));
    end
    pend_done = pend_drop || (|pend_hit);
  end

  // State machine, channel counters, registered tick/level outputs and the pending slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tick        <= '0;
      lvl         <= '0;
      pend_valid  <= 1'b0;
      pend_ch     <= '0;
      pend_period <= '0;
      for (int i = 0; i < 3; i++) begin
        cnt[i] <= '0;
      end
      period[0] <= CW'(P0_DEFAULT);
      period[1] <= CW'(P1_DEFAULT);
      period[2] <= CW'(P2_DEFAULT);
    end else begin
      if (!run) begin
        state_q <= IDLE;
      end else begin
        unique case (state_q)
          IDLE:    state_q <= pause ? PAUSED : RUN;
          RUN:     state_q <= pause ? PAUSED : RUN;
          PAUSED:  state_q <= pause ? PAUSED : RUN;
          default: state_q <= IDLE;
        endcase
      end

      for (int i = 0; i < 3; i++) begin
        if (!run) begin
          cnt[i]  <= '0;
          lvl[i]  <= 1'b0;
          tick[i] <= 1'b0;
        end else if (wrap[i]) begin
          cnt[i]  <= '0;
          lvl[i]  <= ~lvl[i];
          tick[i] <= 1'b1;
        end else begin
          tick[i] <= 1'b0;
          if (count_en && (period[i] != '0)) begin
            cnt[i] <= cnt[i] + CW'(1);
          end
        end

        if (pend_hit[i]) begin
          period[i] <= pend_period;
          cnt[i]    <= '0;
        end else if (wr_direct[i]) begin
          period[i] <= cfg_period;
          cnt[i]    <= '0;
        end
      end

      if (pend_done) begin
        pend_valid <= 1'b0;
      end else if (latch) begin
        pend_valid  <= 1'b1;
        pend_ch     <= cfg_ch;
        pend_period <= cfg_period;
      end
    end
  end

endmodule
